// File: rtl/m_mem_ctrl_pkg.sv
// m_mem_ctrl_pkg
// Shared definitions for the M-stage data-memory sequencer:
//   - memory op codes (MEMOP_NONE..MEMOP_SB); codes 9-15 behave as NONE
//   - FSM state encodings (ST_IDLE, ST_REQ, ST_DONE)
//   - op classification, alignment and store-formatting helpers
package m_mem_ctrl_pkg;

    typedef enum logic [3:0] {
        MEMOP_NONE = 4'd0,
        MEMOP_LW   = 4'd1,
        MEMOP_LH   = 4'd2,
        MEMOP_LHU  = 4'd3,
        MEMOP_LB   = 4'd4,
        MEMOP_LBU  = 4'd5,
        MEMOP_SW   = 4'd6,
        MEMOP_SH   = 4'd7,
        MEMOP_SB   = 4'd8
    } memop_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_load(input logic [3:0] op);
        return (op == MEMOP_LW) || (op == MEMOP_LH) || (op == MEMOP_LHU) ||
               (op == MEMOP_LB) || (op == MEMOP_LBU);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == MEMOP_SW) || (op == MEMOP_SH) || (op == MEMOP_SB);
    endfunction

    // Word ops need addr[1:0]==0, halfword ops need addr[0]==0; bytes never fault.
    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lo);
        logic mis;
        mis = 1'b0;
        if ((op == MEMOP_LW) || (op == MEMOP_SW))
            mis = (lo != 2'b00);
        else if ((op == MEMOP_LH) || (op == MEMOP_LHU) || (op == MEMOP_SH))
            mis = lo[0];
        return mis;
    endfunction

    // Loads read the whole word, so they enable all four lanes.
    function automatic logic [3:0] store_byteen(input logic [3:0] op, input logic [1:0] lo);
        logic [3:0] be;
        be = 4'b1111;
        if (op == MEMOP_SH)
            be = lo[1] ? 4'b1100 : 4'b0011;
        else if (op == MEMOP_SB)
            be = 4'b0001 << lo;
        return be;
    endfunction

    // Replicate the narrow store data across all lanes; byteen picks the live one.
    function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] wd);
        logic [31:0] d;
        d = 32'h0;
        if (op == MEMOP_SW)
            d = wd;
        else if (op == MEMOP_SH)
            d = {2{wd[15:0]}};
        else if (op == MEMOP_SB)
            d = {4{wd[7:0]}};
        return d;
    endfunction

endpackage

// File: rtl/m_mem_ctrl_if.sv
// m_mem_ctrl_if
// Word-wide data-memory bus with a req/ack handshake.
//   mem_req    controller -> memory  request active
//   mem_we     controller -> memory  1 = write
//   mem_addr   controller -> memory  word address (low two bits zero)
//   mem_byteen controller -> memory  byte write enables
//   mem_wdata  controller -> memory  lane-replicated store data
//   mem_ack    memory -> controller  access complete
//   mem_rdata  memory -> controller  read word, valid with mem_ack
interface m_mem_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_byteen;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_byteen, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_byteen, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/m_mem_ctrl_load_ext.sv
// m_load_ext
// Combinational load extractor: selects the byte/halfword addressed by lo
// from a memory word and sign- or zero-extends it according to op.
//   op   in  4   memory op code
//   lo   in  2   addr[1:0] of the access
//   word in  32  memory word
//   ext  out 32  extended load result (0 for stores / NONE)
module m_load_ext
    import m_mem_ctrl_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  lo,
    input  logic [31:0] word,
    output logic [31:0] ext
);

    logic [7:0]  lane [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = word[8*gi +: 8];
        end
    endgenerate

    assign sel_byte = lane[lo];
    assign sel_half = lo[1] ? word[31:16] : word[15:0];

    always_comb begin
        ext = 32'h0;
        case (op)
            MEMOP_LW:  ext = word;
            MEMOP_LH:  ext = {{16{sel_half[15]}}, sel_half};
            MEMOP_LHU: ext = {16'h0, sel_half};
            MEMOP_LB:  ext = {{24{sel_byte[7]}}, sel_byte};
            MEMOP_LBU: ext = {24'h0, sel_byte};
            default:   ext = 32'h0;
        endcase
    end

endmodule

// File: rtl/m_mem_ctrl.sv
// m_mem_ctrl
// M-stage data-memory access sequencer. Accepts one aligned load/store,
// runs it over the req/ack memory bus, stalls the pipeline until the access
// finishes, and presents the extended load result for one DONE cycle.
// An ack missing for MAX_WAIT request cycles ends the access with bus_err.
//   clk, reset         clock, synchronous active-high reset
//   op_valid/op/addr/wdata  memory instruction from the M stage
//   stall              freeze F/D/E/M
//   rdata, done, bus_err    completion (rdata holds until the next DONE)
//   adel, ades         misaligned load / store (IDLE only)
//   mem                memory bus (master side)
module m_mem_ctrl
    import m_mem_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         op_valid,
    input  logic [3:0]   op,
    input  logic [31:0]  addr,
    input  logic [31:0]  wdata,
    output logic         stall,
    output logic [31:0]  rdata,
    output logic         done,
    output logic         adel,
    output logic         ades,
    output logic         bus_err,
    m_mem_ctrl_if.master mem
);

    state_e      state_q,  state_d;
    logic [7:0]  cnt_q,    cnt_d;
    logic [31:0] maddr_q,  maddr_d;
    logic        we_q,     we_d;
    logic [3:0]  byteen_q, byteen_d;
    logic [31:0] mwdata_q, mwdata_d;
    logic [3:0]  op_q,     op_d;
    logic [1:0]  lo_q,     lo_d;
    logic [31:0] word_q,   word_d;
    logic        err_q,    err_d;
    logic [31:0] rdata_q,  rdata_d;

    logic        in_idle;
    logic        op_ok;
    logic        mis;
    logic        accept;
    logic [31:0] ext_word;
    logic [31:0] result;

    m_load_ext u_load_ext (
        .op   (op_q),
        .lo   (lo_q),
        .word (word_q),
        .ext  (ext_word)
    );

    // A timed-out access returns zero regardless of op.
    assign result = err_q ? 32'h0 : ext_word;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        maddr_d  = maddr_q;
        we_d     = we_q;
        byteen_d = byteen_q;
        mwdata_d = mwdata_q;
        op_d     = op_q;
        lo_d     = lo_q;
        word_d   = word_q;
        err_d    = err_q;
        rdata_d  = rdata_q;

        in_idle = (state_q == ST_IDLE);
        op_ok   = is_load(op) || is_store(op);
        mis     = is_misaligned(op, addr[1:0]);
        accept  = in_idle && op_valid && op_ok && !mis;
        adel    = in_idle && op_valid && is_load(op)  && mis;
        ades    = in_idle && op_valid && is_store(op) && mis;
        stall   = accept || (state_q == ST_REQ);

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d  = ST_REQ;
                    cnt_d    = 8'd0;
                    maddr_d  = {addr[31:2], 2'b00};
                    we_d     = is_store(op);
                    byteen_d = store_byteen(op, addr[1:0]);
                    mwdata_d = store_data(op, wdata);
                    op_d     = op;
                    lo_d     = addr[1:0];
                    err_d    = 1'b0;
                end
            end
            ST_REQ: begin
                // An ack on the last allowed cycle still counts as success.
                if (mem.mem_ack) begin
                    word_d  = mem.mem_rdata;
                    state_d = ST_DONE;
                end else if (cnt_q == 8'(MAX_WAIT - 1)) begin
                    word_d  = 32'h0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                rdata_d = result;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            maddr_q  <= '0;
            we_q     <= 1'b0;
            byteen_q <= '0;
            mwdata_q <= '0;
            op_q     <= '0;
            lo_q     <= '0;
            word_q   <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            maddr_q  <= maddr_d;
            we_q     <= we_d;
            byteen_q <= byteen_d;
            mwdata_q <= mwdata_d;
            op_q     <= op_d;
            lo_q     <= lo_d;
            word_q   <= word_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign done           = (state_q == ST_DONE);
    assign bus_err        = done && err_q;
    // During DONE the fresh result is shown; afterwards the stored copy holds.
    assign rdata          = done ? result : rdata_q;
    assign mem.mem_req    = (state_q == ST_REQ);
    assign mem.mem_we     = we_q;
    assign mem.mem_addr   = maddr_q;
    assign mem.mem_byteen = byteen_q;
    assign mem.mem_wdata  = mwdata_q;

endmodule

// File: tb/tb_m_mem_ctrl.sv
module tb_m_mem_ctrl;
    import m_mem_ctrl_pkg::*;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        done;
    logic        adel;
    logic        ades;
    logic        bus_err;

    m_mem_ctrl_if bus ();

    m_mem_ctrl #(.MAX_WAIT(MAXW)) dut (
        .clk      (clk),
        .reset    (reset),
        .op_valid (op_valid),
        .op       (op),
        .addr     (addr),
        .wdata    (wdata),
        .stall    (stall),
        .rdata    (rdata),
        .done     (done),
        .adel     (adel),
        .ades     (ades),
        .bus_err  (bus_err),
        .mem      (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One access: cycle 0 accept, `waits` REQ cycles without ack (ack on the
    // next one unless a timeout is expected), then DONE, then idle.
    task automatic run_op(input string name, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rw, input int waits,
                          input logic eerr, input logic [3:0] be, input logic we,
                          input logic [31:0] ewd, input logic chk_wd, input logic [31:0] erd);
        exp_t e;
        sb.push_back('{rd: erd, err: eerr});
        op_valid = 1'b1; op = o; addr = a; wdata = wd;
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
        @(negedge clk);
        chk({name, ".c0_stall"}, stall, 1'b1);
        chk({name, ".c0_req"}, bus.mem_req, 1'b0);
        chk({name, ".c0_adel_ades"}, {adel, ades}, 2'b00);
        next_cycle();
        for (int c = 0; c <= waits; c++) begin
            bus.mem_ack   = (c == waits) && !eerr;
            bus.mem_rdata = rw;
            @(negedge clk);
            chk($sformatf("%s.req%0d", name, c), bus.mem_req, 1'b1);
            chk($sformatf("%s.addr%0d", name, c), bus.mem_addr, {a[31:2], 2'b00});
            chk($sformatf("%s.be%0d", name, c), bus.mem_byteen, be);
            chk($sformatf("%s.we%0d", name, c), bus.mem_we, we);
            if (chk_wd)
                chk($sformatf("%s.wd%0d", name, c), bus.mem_wdata, ewd);
            chk($sformatf("%s.stall%0d", name, c), stall, 1'b1);
            chk($sformatf("%s.done%0d", name, c), done, 1'b0);
            next_cycle();
        end
        bus.mem_ack = 1'b0;
        op_valid    = 1'b0;
        @(negedge clk);
        chk({name, ".done"}, done, 1'b1);
        chk({name, ".done_stall"}, stall, 1'b0);
        chk({name, ".done_req"}, bus.mem_req, 1'b0);
        if (sb.size() == 0) begin
            chk({name, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({name, ".rdata"}, rdata, e.rd);
            chk({name, ".bus_err"}, bus_err, e.err);
        end
        next_cycle();
        @(negedge clk);
        chk({name, ".idle_done"}, done, 1'b0);
        chk({name, ".idle_err"}, bus_err, 1'b0);
        chk({name, ".idle_req"}, bus.mem_req, 1'b0);
        chk({name, ".rdata_hold"}, rdata, erd);
        $display("txn %s op=%0d addr=%h rdata=%h bus_err=%0b", name, o, a, rdata, eerr);
        next_cycle();
    endtask

    initial begin
        reset = 1'b1; op_valid = 1'b0; op = 4'd0; addr = 32'h0; wdata = 32'h0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
        next_cycle(); next_cycle();
        @(negedge clk);
        chk("rst.req", bus.mem_req, 1'b0);
        chk("rst.we", bus.mem_we, 1'b0);
        chk("rst.addr", bus.mem_addr, 32'h0);
        chk("rst.be", bus.mem_byteen, 4'h0);
        chk("rst.wd", bus.mem_wdata, 32'h0);
        chk("rst.rdata", rdata, 32'h0);
        chk("rst.done_err_stall", {done, bus_err, stall}, 3'b000);
        $display("txn reset");
        next_cycle();
        reset = 1'b0;
        next_cycle();

        //      name    op         addr          wdata         mem_rdata     w  err be       we   ewd           chk  erd
        run_op("LW",   MEMOP_LW,  32'h0000_1000, 32'h0,        32'hDEADBEEF, 0, 0, 4'b1111, 1'b0, 32'h0,        0, 32'hDEADBEEF);
        run_op("LB",   MEMOP_LB,  32'h0000_1003, 32'h0,        32'h80FF7F01, 0, 0, 4'b1111, 1'b0, 32'h0,        0, 32'hFFFFFF80);
        run_op("LBU",  MEMOP_LBU, 32'h0000_1003, 32'h0,        32'h80FF7F01, 1, 0, 4'b1111, 1'b0, 32'h0,        0, 32'h00000080);
        run_op("LB0",  MEMOP_LB,  32'h0000_1000, 32'h0,        32'h80FF7F01, 0, 0, 4'b1111, 1'b0, 32'h0,        0, 32'h00000001);
        run_op("LH",   MEMOP_LH,  32'h0000_1002, 32'h0,        32'h80FF7F01, 0, 0, 4'b1111, 1'b0, 32'h0,        0, 32'hFFFF80FF);
        run_op("LHU",  MEMOP_LHU, 32'h0000_1002, 32'h0,        32'h80FF7F01, 2, 0, 4'b1111, 1'b0, 32'h0,        0, 32'h000080FF);
        run_op("LH0",  MEMOP_LH,  32'h0000_1000, 32'h0,        32'h80FF7F01, 0, 0, 4'b1111, 1'b0, 32'h0,        0, 32'h00007F01);
        run_op("TOUT", MEMOP_LW,  32'h0000_4000, 32'h0,        32'h12345678, MAXW-1, 1, 4'b1111, 1'b0, 32'h0,   0, 32'h00000000);
        run_op("SB",   MEMOP_SB,  32'h0000_2001, 32'h000000AB, 32'h0,        3, 0, 4'b0010, 1'b1, 32'hABABABAB, 1, 32'h00000000);
        run_op("SH",   MEMOP_SH,  32'h0000_2002, 32'h00001234, 32'h0,        0, 0, 4'b1100, 1'b1, 32'h12341234, 1, 32'h00000000);
        run_op("SW",   MEMOP_SW,  32'h0000_2004, 32'h11223344, 32'h0,        1, 0, 4'b1111, 1'b1, 32'h11223344, 1, 32'h00000000);

        // Misaligned accesses: flagged, no request, no stall.
        op_valid = 1'b1; op = MEMOP_LW; addr = 32'h0000_3002;
        @(negedge clk);
        chk("misLW.adel_ades", {adel, ades}, 2'b10);
        chk("misLW.stall", stall, 1'b0);
        next_cycle();
        @(negedge clk);
        chk("misLW.req", bus.mem_req, 1'b0);
        $display("txn misaligned LW addr=%h adel=%0b", addr, adel);
        op = MEMOP_SH; addr = 32'h0000_3001;
        @(negedge clk);
        chk("misSH.adel_ades", {adel, ades}, 2'b01);
        chk("misSH.stall", stall, 1'b0);
        next_cycle();
        @(negedge clk);
        chk("misSH.req", bus.mem_req, 1'b0);
        chk("misSH.done", done, 1'b0);
        $display("txn misaligned SH addr=%h ades=%0b", addr, ades);
        op_valid = 1'b0;
        next_cycle();

        // Leave a nonzero rdata so the reset clearing it is visible.
        run_op("LW2",  MEMOP_LW,  32'h0000_5000, 32'h0,        32'hCAFEF00D, 0, 0, 4'b1111, 1'b0, 32'h0,        0, 32'hCAFEF00D);

        // Reset in the second REQ cycle, together with an ack: reset wins.
        op_valid = 1'b1; op = MEMOP_SW; addr = 32'h0000_6000; wdata = 32'h55AA55AA;
        next_cycle();
        @(negedge clk);
        chk("rreq.req1", bus.mem_req, 1'b1);
        next_cycle();
        reset = 1'b1; bus.mem_ack = 1'b1; bus.mem_rdata = 32'h12345678;
        @(negedge clk);
        chk("rreq.req2", bus.mem_req, 1'b1);
        next_cycle();
        reset = 1'b0; op_valid = 1'b0;
        @(negedge clk);
        chk("rreq.req_after", bus.mem_req, 1'b0);
        chk("rreq.addr", bus.mem_addr, 32'h0);
        chk("rreq.be", bus.mem_byteen, 4'h0);
        chk("rreq.we", bus.mem_we, 1'b0);
        chk("rreq.wd", bus.mem_wdata, 32'h0);
        chk("rreq.rdata", rdata, 32'h0);
        chk("rreq.done_err_stall", {done, bus_err, stall}, 3'b000);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            @(negedge clk);
            chk($sformatf("rreq.stray_done%0d", i), done, 1'b0);
            chk($sformatf("rreq.stray_req%0d", i), bus.mem_req, 1'b0);
        end
        bus.mem_ack = 1'b0;
        $display("txn reset-during-REQ with stray ack");
        chk("sb.empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
